// File: rtl/mips32_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mips32_run_ctrl
//  Purpose  : Host-loadable instruction memory plus LOAD/RUN/YIELD/HALT
//             sequencer that clock-enables a MIPS32 core and counts retirements.
//  Revision : 1.0  initial release
// ============================================================================
module mips32_run_ctrl #(
    parameter int ADDR_W       = 6,
    parameter int YIELD_CYCLES = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
    output logic              load_ready,
    input  logic              start,
    input  logic [ADDR_W-1:0] cpu_raddr,
    output logic [31:0]       cpu_instr,
    output logic              cpu_step,
    output logic [1:0]        state,
    output logic [31:0]       retired
);

    localparam int          DEPTH         = 1 << ADDR_W;
    localparam logic [31:0] C_YIELD_INSTR = 32'h114b0001;
    localparam logic [5:0]  C_HALT_FUNCT  = 6'd13;
    localparam logic [7:0]  C_YIELD_LOAD  = 8'(YIELD_CYCLES);
    localparam logic [31:0] C_RET_MAX     = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_YIELD = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    generate
        if (YIELD_CYCLES < 1 || YIELD_CYCLES > 255) begin : g_yield_range_check
            $error("mips32_run_ctrl: YIELD_CYCLES must lie in 1..255");
        end
    endgenerate

    state_t      state_q, state_d;
    logic [31:0] retired_q, retired_d;
    logic [7:0]  ycnt_q, ycnt_d;

    logic [31:0] mem [DEPTH];
    logic        mem_we;
    logic [31:0] rd_word;
    logic        is_halt;
    logic        is_yield;

    // Core-facing outputs come only from the state register and cpu_raddr,
    // so no host input can reach the core combinationally.
    assign rd_word = mem[cpu_raddr];

    always_comb begin
        cpu_step   = (state_q == ST_RUN);
        cpu_instr  = cpu_step ? rd_word : 32'h0;
        load_ready = (state_q == ST_LOAD);
        state      = state_q;
        retired    = retired_q;
        is_halt    = (cpu_instr[5:0] == C_HALT_FUNCT);
        is_yield   = (cpu_instr == C_YIELD_INSTR);
        mem_we     = load_valid & load_ready;
    end

    always_comb begin
        state_d   = state_q;
        retired_d = retired_q;
        ycnt_d    = ycnt_q;
        unique case (state_q)
            ST_LOAD: begin
                if (start) begin
                    state_d   = ST_RUN;
                    retired_d = 32'h0;
                end
            end
            ST_RUN: begin
                if (retired_q != C_RET_MAX) begin
                    retired_d = retired_q + 32'd1;
                end
                // Halt wins over yield when an encoding matches both.
                if (is_halt) begin
                    state_d = ST_HALT;
                end else if (is_yield) begin
                    state_d = ST_YIELD;
                    ycnt_d  = C_YIELD_LOAD;
                end
            end
            ST_YIELD: begin
                ycnt_d = ycnt_q - 8'd1;
                if (ycnt_q <= 8'd1) begin
                    state_d = ST_RUN;
                end
            end
            ST_HALT: begin
                if (start) begin
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_LOAD;
            retired_q <= 32'h0;
            ycnt_q    <= 8'h0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
            ycnt_q    <= ycnt_d;
        end
    end

    // Program storage deliberately has no reset so a loaded image survives it.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[load_addr] <= load_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mips32_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mips32_run_ctrl
//  Purpose  : Randomised scoreboard bench for mips32_run_ctrl against a
//             cycle-level behavioural model of the run controller.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mips32_run_ctrl;

    localparam int          AW      = 6;
    localparam int          YC      = 4;
    localparam logic [31:0] YIELD_W = 32'h114b0001;
    localparam logic [31:0] HALT_W  = 32'h0000000D;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          load_valid = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [31:0]   load_data = '0;
    logic          load_ready;
    logic          start = 1'b0;
    logic [AW-1:0] cpu_raddr = '0;
    logic [31:0]   cpu_instr;
    logic          cpu_step;
    logic [1:0]    state;
    logic [31:0]   retired;

    mips32_run_ctrl #(.ADDR_W(AW), .YIELD_CYCLES(YC)) dut (
        .clock     (clock),
        .reset     (reset),
        .load_valid(load_valid),
        .load_addr (load_addr),
        .load_data (load_data),
        .load_ready(load_ready),
        .start     (start),
        .cpu_raddr (cpu_raddr),
        .cpu_instr (cpu_instr),
        .cpu_step  (cpu_step),
        .state     (state),
        .retired   (retired)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  st;
        logic        step;
        logic        rdy;
        logic [31:0] instr;
        logic [31:0] ret;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   ncyc     = 0;

    // Reference model: 0=LOAD 1=RUN 2=YIELD 3=HALT
    int            m_state = 0;
    logic [31:0]   m_ret   = 0;
    int            m_yleft = 0;
    logic [31:0]   m_mem [1<<AW];
    logic [AW-1:0] core_pc = '0;

    task automatic chk(input string nm, input int cyc, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
        end
    endtask

    // Monitor: samples mid-cycle, away from the active edge.
    always @(negedge clock) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("state",      e.cyc, 32'(state),      32'(e.st));
            chk("cpu_step",   e.cyc, 32'(cpu_step),   32'(e.step));
            chk("load_ready", e.cyc, 32'(load_ready), 32'(e.rdy));
            chk("cpu_instr",  e.cyc, cpu_instr,       e.instr);
            chk("retired",    e.cyc, retired,         e.ret);
        end
    end

    task automatic cycle(input logic lv, input logic [AW-1:0] la, input logic [31:0] ld,
                         input logic st, input logic rs);
        exp_t          e;
        logic [AW-1:0] ra;
        logic [31:0]   ins;
        @(posedge clock);
        #1;
        if (m_state == 1 && !rs && $urandom_range(0, 9) != 0) ra = core_pc;
        else ra = AW'($urandom);
        reset = rs; load_valid = lv; load_addr = la; load_data = ld;
        start = st; cpu_raddr = ra;
        if (rs) begin
            m_state = 0; m_ret = 0; m_yleft = 0;
        end
        ins     = (m_state == 1) ? m_mem[ra] : 32'h0;
        e.st    = 2'(m_state);
        e.step  = (m_state == 1);
        e.rdy   = (m_state == 0);
        e.instr = ins;
        e.ret   = m_ret;
        e.cyc   = ncyc;
        q.push_back(e);
        ncyc++;
        if (!rs) begin
            case (m_state)
                0: begin
                    if (lv) m_mem[la] = ld;
                    if (st) begin m_state = 1; m_ret = 0; core_pc = '0; end
                end
                1: begin
                    if (m_ret != 32'hFFFF_FFFF) m_ret = m_ret + 1;
                    core_pc = ra + 1'b1;
                    if (ins[5:0] == 6'd13) m_state = 3;
                    else if (ins == YIELD_W) begin m_state = 2; m_yleft = YC; end
                end
                2: begin
                    m_yleft = m_yleft - 1;
                    if (m_yleft == 0) m_state = 1;
                end
                default: if (st) m_state = 0;
            endcase
        end
    endtask

    task automatic idle(input int n, input logic st);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 32'h0, st, 1'b0);
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        int r;
        r = $urandom_range(0, 99);
        w = $urandom;
        if (r < 10) w = YIELD_W;
        else if (r < 22) w[5:0] = 6'd13;
        else begin
            if (w[5:0] == 6'd13) w[5:0] = 6'd0;
            if (w == YIELD_W) w = 32'h0;
        end
        return w;
    endfunction

    initial begin
        cycle(1'b0, '0, 32'h0, 1'b0, 1'b1);
        cycle(1'b0, '0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < (1 << AW); i++) cycle(1'b1, AW'(i), 32'h0, 1'b0, 1'b0);

        // Three-instruction program ending in halt.
        cycle(1'b1, 6'd0, 32'h20010001, 1'b0, 1'b0);
        cycle(1'b1, 6'd1, 32'h20420002, 1'b0, 1'b0);
        cycle(1'b1, 6'd2, HALT_W,       1'b0, 1'b0);
        idle(1, 1'b1);
        idle(4, 1'b0);

        // HALT -> LOAD keeps retired; write+start in the same cycle.
        idle(1, 1'b1);
        idle(1, 1'b0);
        cycle(1'b1, 6'd0, 32'h20030005, 1'b1, 1'b0);
        idle(4, 1'b0);
        idle(1, 1'b1);

        // Yield at word 1; start held through RUN and YIELD is ignored.
        cycle(1'b1, 6'd1, YIELD_W, 1'b0, 1'b0);
        idle(1, 1'b1);
        idle(6, 1'b1);
        idle(3, 1'b0);
        idle(1, 1'b1);

        // Host writes while not in LOAD must be dropped.
        cycle(1'b1, 6'd2, 32'h20040004, 1'b0, 1'b0);
        cycle(1'b1, 6'd3, 32'h20050005, 1'b0, 1'b0);
        cycle(1'b1, 6'd4, 32'h20060006, 1'b0, 1'b0);
        cycle(1'b1, 6'd5, HALT_W,       1'b0, 1'b0);
        idle(1, 1'b1);
        for (int i = 0; i < 12; i++) cycle(1'b1, 6'd5, 32'hDEADBEEF, 1'b0, 1'b0);
        idle(1, 1'b1);
        cycle(1'b0, '0, 32'h0, 1'b1, 1'b0);
        idle(12, 1'b0);
        idle(1, 1'b1);

        // Reset lands on the second YIELD cycle, then the program reruns.
        idle(1, 1'b1);
        idle(3, 1'b0);
        cycle(1'b0, '0, 32'h0, 1'b0, 1'b1);
        idle(1, 1'b0);
        idle(1, 1'b1);
        idle(13, 1'b0);
        idle(1, 1'b1);

        // Randomised phase over a fully random program image.
        for (int i = 0; i < (1 << AW); i++) cycle(1'b1, AW'(i), rand_word(), 1'b0, 1'b0);
        for (int i = 0; i < 4000; i++) begin
            logic rs;
            rs = ($urandom_range(0, 249) == 0);
            cycle(rs ? 1'b0 : 1'($urandom_range(0, 1)), AW'($urandom), rand_word(),
                  ($urandom_range(0, 7) == 0), rs);
        end

        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clock);
        if (q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
